// File: rtl/mult_div_unit.sv
// Multicycle integer multiply/divide engine driving the HIGH/LOW registers.
// Supports MULT, MULTU, DIV and DIVU. A multiply uses shift-add and a divide
// uses restoring division, one bit per cycle, on operand magnitudes. Sign
// correction is applied when the result is written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             start,
  input  logic [1:0]       op,        // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cnt;
  logic                   r_is_div, r_dz, r_neg_lo, r_neg_hi;
  logic [2*WIDTH-1:0]     r_acc;       // multiply: {partial product, multiplier}
  logic [WIDTH-1:0]       r_rem;       // divide: partial remainder (always < divisor)
  logic [WIDTH-1:0]       r_quo;       // divide: dividend shifting out, quotient in
  logic [WIDTH-1:0]       r_opb;       // multiplicand / divisor magnitude
  logic                   r_done, r_div_zero;
  logic [WIDTH-1:0]       r_hi, r_lo;

  // Operand decode for the start cycle
  logic                   w_signed, w_is_div, w_b_zero, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]       w_mag_a, w_mag_b;

  assign w_signed = ~op[0];
  assign w_is_div = op[1];
  assign w_b_zero = (b == '0);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? -a : a;
  assign w_mag_b  = w_b_neg ? -b : b;

  // One iteration of each algorithm
  logic [WIDTH:0]         w_mul_sum;
  logic [WIDTH:0]         w_div_shift;  // WIDTH+1-bit shifted partial remainder
  logic [WIDTH-1:0]       w_div_diff;
  logic                   w_div_fit;

  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_fit   = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;

  // Sign-corrected results
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo_fin, w_rem_fin;

  assign w_prod    = r_neg_lo ? -r_acc : r_acc;
  assign w_quo_fin = r_neg_lo ? -r_quo : r_quo;
  assign w_rem_fin = r_neg_hi ? -r_rem : r_rem;

  // Divide-by-zero waits one extra cycle in FINISH (r_cnt loaded with 1)
  logic                   w_dz_hold;
  assign w_dz_hold = r_dz && (r_cnt != '0);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (w_is_div && w_b_zero) ? FINISH : RUN;
      RUN:     if (r_cnt == CW'(1)) w_next = FINISH;
      FINISH:  if (!w_dz_hold) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, write hi/lo and pulse done on FINISH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_opb      <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div <= w_is_div;
            r_dz     <= w_is_div & w_b_zero;
            r_cnt    <= (w_is_div && w_b_zero) ? CW'(1) : CW'(WIDTH);
            r_neg_lo <= w_a_neg ^ w_b_neg;   // product sign / quotient sign
            r_neg_hi <= w_a_neg;             // remainder follows the dividend
            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_opb    <= w_mag_b;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_is_div) begin
            r_rem <= w_div_fit ? w_div_diff : w_div_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_div_fit};
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        FINISH: begin
          if (w_dz_hold) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_done <= 1'b1;
            if (r_dz) begin
              r_div_zero <= 1'b1;
            end else if (r_is_div) begin
              r_hi <= w_rem_fin;
              r_lo <= w_quo_fin;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a 32-bit instance and an 8-bit instance.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, busy, done, div_zero;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;

  logic        start8, busy8, done8, div_zero8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int checks = 0;
  int errors = 0;
  int cyc, bcyc, pulses;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 32-bit unit; returns cycles until done and cycles busy.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit disturb, output int c, output int bc);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    c  = 0;
    bc = busy ? 1 : 0;
    while (!done && c < 100) begin
      if (disturb && c == 4) begin start = 1'b1; op = 2'b01; a = 32'h5; b = 32'h3; end
      if (disturb && c == 8) begin start = 1'b0; a = 32'h0; end
      tick();
      c++;
      if (busy) bc++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int c);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    c = 0;
    while (!done8 && c < 100) begin
      tick();
      c++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz",   div_zero, 0);
    check("rst_hi",   hi, 0);
    check("rst_lo",   lo, 0);
    check("rst_busy8", busy8, 0);
    rst = 1'b1;
    tick();

    // MULT -3 * 7
    run32(2'b00, 32'hFFFF_FFFD, 32'h7, 1'b0, cyc, bcyc);
    check("mult_lat",  cyc, 33);
    check("mult_busy", bcyc, 33);
    check("mult_hi",   hi, 32'hFFFF_FFFF);
    check("mult_lo",   lo, 32'hFFFF_FFEB);
    check("mult_dz",   div_zero, 0);
    tick();
    check("done_pulse", done, 0);
    check("hold_lo",    lo, 32'hFFFF_FFEB);

    // MULTU FFFFFFFF * FFFFFFFF
    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, bcyc);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_dz", div_zero, 0);

    // MULT -1 * -1
    run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, bcyc);
    check("mult_nn_hi", hi, 32'h0);
    check("mult_nn_lo", lo, 32'h1);

    // DIV -7 / 2, then DIVU 7 / 2 started in the done cycle
    run32(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0, cyc, bcyc);
    check("div_lo",  lo, 32'hFFFF_FFFD);
    check("div_hi",  hi, 32'hFFFF_FFFF);
    check("div_lat", cyc, 33);
    run32(2'b11, 32'h7, 32'h2, 1'b0, cyc, bcyc);
    check("b2b_lat",  cyc, 33);
    check("divu_lo",  lo, 32'h3);
    check("divu_hi",  hi, 32'h1);

    // DIV 5 / 0 with hi/lo = 1/3
    run32(2'b10, 32'h5, 32'h0, 1'b0, cyc, bcyc);
    check("dz_lat",  cyc, 2);
    check("dz_busy", bcyc, 2);
    check("dz_flag", div_zero, 1);
    check("dz_hi",   hi, 32'h1);
    check("dz_lo",   lo, 32'h3);
    tick();
    check("dz_pulse", div_zero, 0);

    // DIV 7 / -2
    run32(2'b10, 32'h7, 32'hFFFF_FFFE, 1'b0, cyc, bcyc);
    check("div_pn_lo", lo, 32'hFFFF_FFFD);
    check("div_pn_hi", hi, 32'h1);

    // DIV most-negative / -1 with input disturbance during RUN
    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc, bcyc);
    check("ovf_lat", cyc, 33);
    check("ovf_lo",  lo, 32'h8000_0000);
    check("ovf_hi",  hi, 32'h0);
    check("ovf_dz",  div_zero, 0);

    // Reset mid-RUN
    op = 2'b01; a = 32'h1234; b = 32'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hi",   hi, 0);
    check("arst_lo",   lo, 0);
    check("arst_done", done, 0);
    repeat (2) tick();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check("arst_nodone", pulses, 0);
    check("arst_idle",   busy, 0);

    // 8-bit instance
    run8(2'b01, 8'hFF, 8'hFF, cyc);
    check("w8_lat", cyc, 9);
    check("w8_hi",  hi8, 8'hFE);
    check("w8_lo",  lo8, 8'h01);
    run8(2'b10, 8'h80, 8'hFF, cyc);
    check("w8_ovf_lo", lo8, 8'h80);
    check("w8_ovf_hi", hi8, 8'h00);
    run8(2'b11, 8'hC8, 8'h07, cyc);
    check("w8_divu_lo", lo8, 8'h1C);
    check("w8_divu_hi", hi8, 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
